// File: rtl/sata_bringup_pkg.sv
// Shared state encoding, default timing constants and helpers for the SATA link bring-up sequencer.
package sata_bringup_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_PLL  = 3'd1,
      ST_RESET     = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT_INIT = 3'd4,
      ST_WAIT_LINK = 3'd5,
      ST_UP        = 3'd6,
      ST_FAIL      = 3'd7
   } state_e;

   localparam int unsigned C_RESET_CYCLES_DEF  = 16;
   localparam int unsigned C_INIT_TIMEOUT_DEF  = 750000;
   localparam int unsigned C_LINK_TIMEOUT_DEF  = 75000;
   localparam int unsigned C_MAX_RETRY_DEF     = 3;
   localparam int unsigned C_LOSS_DEBOUNCE_DEF = 8;

   // Largest of three values, used to size the shared timer.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sata_bringup_timer.sv
// Loadable down-counter; expired is high during the last cycle of a loaded interval.
module sata_bringup_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_75m,
   input  logic         host_rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   // Next count: reload on request, otherwise count down and park at zero.
   always_comb begin
      cnt_nxt = cnt;
      if (load) begin
         cnt_nxt = value;
      end else if (cnt != '0) begin
         cnt_nxt = cnt - W'(1);
      end
   end

   // Counter and registered expiry flag (count of one means last cycle).
   always_ff @(posedge clk_75m) begin
      if (host_rst) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         expired <= (cnt_nxt == W'(1));
      end
   end

endmodule

// File: rtl/sata_link_bringup.sv
// Per-port SATA link bring-up sequencer: PHY reset, OOB start, timeouts, retries and loss detection.
module sata_link_bringup
   import sata_bringup_pkg::*;
#(
   parameter int unsigned C_RESET_CYCLES  = C_RESET_CYCLES_DEF,
   parameter int unsigned C_INIT_TIMEOUT  = C_INIT_TIMEOUT_DEF,
   parameter int unsigned C_LINK_TIMEOUT  = C_LINK_TIMEOUT_DEF,
   parameter int unsigned C_MAX_RETRY     = C_MAX_RETRY_DEF,
   parameter int unsigned C_LOSS_DEBOUNCE = C_LOSS_DEBOUNCE_DEF
) (
   input  logic       clk_75m,
   input  logic       host_rst,
   input  logic       enable,
   input  logic       plllock,
   input  logic       CommInit,
   input  logic       linkup,
   output logic       phyreset,
   output logic       StartComm,
   output logic       link_ready,
   output logic       link_fail,
   output logic       link_lost,
   output logic [3:0] retry_cnt,
   output logic [2:0] state_dbg
);

   localparam int unsigned TMR_W  = $clog2(max3(C_RESET_CYCLES, C_INIT_TIMEOUT, C_LINK_TIMEOUT)) + 1;
   localparam int unsigned LOSS_W = $clog2(C_LOSS_DEBOUNCE) + 1;

   state_e            state;
   state_e            state_nxt;
   logic [3:0]        retry_nxt;
   logic [3:0]        retry_inc;
   logic [LOSS_W-1:0] loss_cnt;
   logic [LOSS_W-1:0] loss_nxt;
   logic              lost_nxt;
   logic              do_retry;
   logic              tmr_load_c;
   logic [TMR_W-1:0]  tmr_value_c;
   logic              tmr_expired;

   sata_bringup_timer #(.W(TMR_W)) u_timer (
      .clk_75m  (clk_75m),
      .host_rst (host_rst),
      .load     (tmr_load_c),
      .value    (tmr_value_c),
      .expired  (tmr_expired)
   );

   // Next state, retry/loss bookkeeping and timer loads, in priority order.
   always_comb begin
      state_nxt   = state;
      retry_nxt   = retry_cnt;
      loss_nxt    = '0;
      lost_nxt    = 1'b0;
      do_retry    = 1'b0;
      tmr_load_c  = 1'b0;
      tmr_value_c = '0;
      retry_inc   = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

      if (!enable) begin
         state_nxt = ST_IDLE;
         retry_nxt = '0;
      end else if (!plllock &&
                   (state inside {ST_RESET, ST_START, ST_WAIT_INIT, ST_WAIT_LINK, ST_UP})) begin
         state_nxt = ST_WAIT_PLL;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_WAIT_PLL;
            ST_WAIT_PLL: begin
               if (plllock) begin
                  state_nxt   = ST_RESET;
                  tmr_load_c  = 1'b1;
                  tmr_value_c = TMR_W'(C_RESET_CYCLES);
               end
            end
            ST_RESET: begin
               if (tmr_expired) state_nxt = ST_START;
            end
            ST_START: begin
               state_nxt   = ST_WAIT_INIT;
               tmr_load_c  = 1'b1;
               tmr_value_c = TMR_W'(C_INIT_TIMEOUT);
            end
            ST_WAIT_INIT: begin
               if (CommInit) begin
                  state_nxt   = ST_WAIT_LINK;
                  tmr_load_c  = 1'b1;
                  tmr_value_c = TMR_W'(C_LINK_TIMEOUT);
               end else if (tmr_expired) begin
                  do_retry = 1'b1;
               end
            end
            ST_WAIT_LINK: begin
               if (linkup) begin
                  state_nxt = ST_UP;
               end else if (tmr_expired) begin
                  do_retry = 1'b1;
               end
            end
            ST_UP: begin
               if (!linkup) begin
                  if (loss_cnt == LOSS_W'(C_LOSS_DEBOUNCE - 1)) begin
                     lost_nxt    = 1'b1;
                     retry_nxt   = '0;
                     state_nxt   = ST_RESET;
                     tmr_load_c  = 1'b1;
                     tmr_value_c = TMR_W'(C_RESET_CYCLES);
                  end else begin
                     loss_nxt = loss_cnt + LOSS_W'(1);
                  end
               end
            end
            ST_FAIL: state_nxt = ST_FAIL;
            default: state_nxt = ST_IDLE;
         endcase

         // A failed attempt either restarts the PHY reset or gives up.
         if (do_retry) begin
            retry_nxt = retry_inc;
            if (retry_inc == 4'(C_MAX_RETRY)) begin
               state_nxt = ST_FAIL;
            end else begin
               state_nxt   = ST_RESET;
               tmr_load_c  = 1'b1;
               tmr_value_c = TMR_W'(C_RESET_CYCLES);
            end
         end
      end
   end

   // State, counters and outputs, all registered from the next state.
   always_ff @(posedge clk_75m) begin
      if (host_rst) begin
         state      <= ST_IDLE;
         retry_cnt  <= '0;
         loss_cnt   <= '0;
         phyreset   <= 1'b1;
         StartComm  <= 1'b0;
         link_ready <= 1'b0;
         link_fail  <= 1'b0;
         link_lost  <= 1'b0;
      end else begin
         state      <= state_nxt;
         retry_cnt  <= retry_nxt;
         loss_cnt   <= loss_nxt;
         phyreset   <= !(state_nxt inside {ST_START, ST_WAIT_INIT, ST_WAIT_LINK, ST_UP});
         StartComm  <= (state_nxt == ST_START);
         link_ready <= (state_nxt == ST_UP);
         link_fail  <= (state_nxt == ST_FAIL);
         link_lost  <= lost_nxt;
      end
   end

   assign state_dbg = 3'(state);

endmodule

// File: tb/tb_sata_link_bringup.sv
// Directed bench for sata_link_bringup with an expected-value scoreboard queue.
module tb_sata_link_bringup;

   logic clk_75m;
   logic host_rst, enable, plllock, comm_init, linkup;

   logic       phyreset_a, start_a, ready_a, fail_a, lost_a;
   logic [3:0] retry_a;
   logic [2:0] state_a;
   logic       phyreset_b, start_b, ready_b, fail_b, lost_b;
   logic [3:0] retry_b;
   logic [2:0] state_b;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   // Instance A: default timing.
   sata_link_bringup u_dut_a (
      .clk_75m(clk_75m), .host_rst(host_rst), .enable(enable), .plllock(plllock),
      .CommInit(comm_init), .linkup(linkup), .phyreset(phyreset_a), .StartComm(start_a),
      .link_ready(ready_a), .link_fail(fail_a), .link_lost(lost_a),
      .retry_cnt(retry_a), .state_dbg(state_a)
   );

   // Instance B: short timeouts for retry, race and PLL-drop scenarios.
   sata_link_bringup #(.C_INIT_TIMEOUT(50), .C_LINK_TIMEOUT(50), .C_MAX_RETRY(3)) u_dut_b (
      .clk_75m(clk_75m), .host_rst(host_rst), .enable(enable), .plllock(plllock),
      .CommInit(comm_init), .linkup(linkup), .phyreset(phyreset_b), .StartComm(start_b),
      .link_ready(ready_b), .link_fail(fail_b), .link_lost(lost_b),
      .retry_cnt(retry_b), .state_dbg(state_b)
   );

   initial clk_75m = 1'b0;
   always #5 clk_75m = ~clk_75m;

   task automatic tick();
      @(posedge clk_75m);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         e.tag = "scoreboard_empty";
         e.exp = 32'hDEAD_BEEF;
      end else begin
         e = sb.pop_front();
      end
      n_assert++;
      assert (obs === e.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
   endtask

   initial begin
      int start_cyc, ready_cyc, lost_cnt, n, hi, starts, dwell;

      host_rst = 1'b1; enable = 1'b0; plllock = 1'b1; comm_init = 1'b0; linkup = 1'b0;
      repeat (3) tick();

      // Reset values
      push("rst_phyreset", 1); push("rst_startcomm", 0); push("rst_ready", 0);
      push("rst_fail", 0); push("rst_lost", 0); push("rst_retry", 0); push("rst_state", 0);
      chk(32'(phyreset_a)); chk(32'(start_a)); chk(32'(ready_a));
      chk(32'(fail_a)); chk(32'(lost_a)); chk(32'(retry_a)); chk(32'(state_a));

      // Happy path: enable at cycle 0, CommInit at 100, linkup from 200
      host_rst = 1'b0;
      tick();
      push("happy_start_cycle", 18); push("happy_ready_cycle", 201);
      push("happy_retry", 0); push("happy_state_up", 6);
      enable = 1'b1;
      start_cyc = -1; ready_cyc = -1;
      for (int c = 1; c <= 210; c++) begin
         tick();
         if (start_a && start_cyc < 0) start_cyc = c;
         if (ready_a && ready_cyc < 0) ready_cyc = c;
         comm_init = (c == 100);
         linkup    = (c >= 200);
      end
      chk(32'(start_cyc)); chk(32'(ready_cyc)); chk(32'(retry_a)); chk(32'(state_a));

      // Link glitch shorter than the debounce: 7 low cycles then high
      push("glitch_no_lost", 0); push("glitch_still_ready", 1);
      lost_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         linkup = (i >= 7);
         tick();
         if (lost_a) lost_cnt++;
      end
      chk(32'(lost_cnt)); chk(32'(ready_a));

      // Debounced loss: 8 low cycles
      push("loss_latency", 8); push("loss_ready", 0); push("loss_phyreset", 1);
      push("loss_retry", 0); push("loss_reset_len", 16); push("loss_single_pulse", 0);
      push("loss_restart", 1); push("loss_phyreset_at_start", 0);
      linkup = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (lost_a) break;
      end
      chk(32'(n)); chk(32'(ready_a)); chk(32'(phyreset_a)); chk(32'(retry_a));
      hi = phyreset_a ? 1 : 0;
      lost_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (lost_a) lost_cnt++;
         if (start_a) break;
         if (phyreset_a) hi++;
      end
      chk(32'(hi)); chk(32'(lost_cnt)); chk(32'(start_a)); chk(32'(phyreset_a));

      // Bring A back to UP, then pulse host_rst
      push("reup_state", 6);
      tick();
      comm_init = 1'b1;
      tick();
      comm_init = 1'b0;
      linkup = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ready_a) break;
      end
      chk(32'(state_a));
      push("midrst_phyreset", 1); push("midrst_startcomm", 0); push("midrst_ready", 0);
      push("midrst_fail", 0); push("midrst_lost", 0); push("midrst_retry", 0);
      push("midrst_state", 0);
      host_rst = 1'b1;
      tick();
      chk(32'(phyreset_a)); chk(32'(start_a)); chk(32'(ready_a));
      chk(32'(fail_a)); chk(32'(lost_a)); chk(32'(retry_a)); chk(32'(state_a));
      host_rst = 1'b0; enable = 1'b0; linkup = 1'b0;
      tick();

      // Init timeout on B: CommInit never asserts
      host_rst = 1'b1;
      tick();
      host_rst = 1'b0;
      push("to_startcomm_pulses", 3); push("to_init_dwell", 50); push("to_retry", 3);
      push("to_fail", 1); push("to_state", 7); push("to_phyreset", 1); push("to_hold_state", 7);
      enable = 1'b1;
      starts = 0; dwell = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (start_b) starts++;
         if (state_b == 3'd4 && starts == 1) dwell++;
         if (fail_b) break;
      end
      chk(32'(starts)); chk(32'(dwell)); chk(32'(retry_b));
      chk(32'(fail_b)); chk(32'(state_b)); chk(32'(phyreset_b));
      tick(); tick();
      chk(32'(state_b));
      push("dis_state", 0); push("dis_retry", 0); push("dis_fail", 0);
      enable = 1'b0;
      tick();
      chk(32'(state_b)); chk(32'(retry_b)); chk(32'(fail_b));

      // Race: CommInit in the expiry cycle of WAIT_INIT
      push("race_pre_state", 4); push("race_state", 5); push("race_retry", 0);
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (state_b == 3'd4) break;
      end
      repeat (49) tick();
      chk(32'(state_b));
      comm_init = 1'b1;
      tick();
      comm_init = 1'b0;
      chk(32'(state_b)); chk(32'(retry_b));

      // Link timeout counts a retry, then PLL drop in WAIT_LINK
      push("lto_dwell", 50); push("lto_state", 2); push("lto_retry", 1);
      dwell = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (state_b != 3'd5) break;
         dwell++;
      end
      chk(32'(dwell)); chk(32'(state_b)); chk(32'(retry_b));
      push("pll_wait_link", 5); push("pll_drop_state", 1); push("pll_drop_retry", 1);
      push("pll_drop_phyreset", 1); push("pll_relock_state", 2); push("pll_relock_retry", 1);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (state_b == 3'd4) break;
      end
      comm_init = 1'b1;
      tick();
      comm_init = 1'b0;
      chk(32'(state_b));
      plllock = 1'b0;
      tick();
      chk(32'(state_b)); chk(32'(retry_b)); chk(32'(phyreset_b));
      plllock = 1'b1;
      tick();
      chk(32'(state_b)); chk(32'(retry_b));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sata_link_bringup.md
# sata_link_bringup

Per-port link bring-up sequencer for the SATA GTX PHY wrapper. It drives `phyreset` and `StartComm` for one port, watches `CommInit`, `linkup` and `plllock`, enforces timeouts, retries, and declares the link ready or failed. One instance sits beside each PHY port, in the port's `phyclk` (`clk_75m`) domain, between the port controller and the PHY wrapper.

## Interface
- `C_RESET_CYCLES`, default 16: cycles `phyreset` is held high per attempt; minimum 1.
- `C_INIT_TIMEOUT`, default 750000: cycles allowed from `StartComm` to `CommInit` (10 ms at 75 MHz).
- `C_LINK_TIMEOUT`, default 75000: cycles allowed from `CommInit` to `linkup` (1 ms).
- `C_MAX_RETRY`, default 3: failed attempts before entering FAIL; range 1..15.
- `C_LOSS_DEBOUNCE`, default 8: consecutive `linkup`=0 cycles in UP that count as link loss; minimum 1.

Ports:
- `clk_75m` in 1: port PHY clock; the only clock.
- `host_rst` in 1: reset, synchronous and active-high.
- `enable` in 1: level request to bring up and hold the link.
- `plllock` in 1: PHY PLL lock, already synchronous to `clk_75m`.
- `CommInit` in 1: OOB COMINIT seen, from the PHY.
- `linkup` in 1: PHY link-up status.
- `phyreset` out 1: PHY reset.
- `StartComm` out 1: one-cycle OOB start pulse.
- `link_ready` out 1: link is up and stable.
- `link_fail` out 1: retries exhausted.
- `link_lost` out 1: one-cycle pulse when a debounced loss is detected in UP.
- `retry_cnt` out 4: failed attempts in the current bring-up.
- `state_dbg` out 3: current state encoding, for `oob2dbg`.

## Operation
- States: IDLE=0, WAIT_PLL=1, RESET=2, START=3, WAIT_INIT=4, WAIT_LINK=5, UP=6, FAIL=7. RETRY is a transition action, not a state.
- IDLE: `phyreset`=1. Go to WAIT_PLL when `enable`=1.
- WAIT_PLL: `phyreset`=1. Go to RESET when `plllock`=1, loading the timer with `C_RESET_CYCLES`.
- RESET: `phyreset`=1 for exactly `C_RESET_CYCLES` cycles, then go to START.
- START: `phyreset`=0 and `StartComm`=1 for exactly 1 cycle. Go to WAIT_INIT, loading the timer with `C_INIT_TIMEOUT`.
- WAIT_INIT:
  - `CommInit`=1: go to WAIT_LINK, loading the timer with `C_LINK_TIMEOUT`.
  - Timer expiry: RETRY.
- WAIT_LINK:
  - `linkup`=1: go to UP; `link_ready`=1 from the next cycle.
  - Timer expiry: RETRY.
- RETRY: `retry_cnt`+1. If the new value equals `C_MAX_RETRY`, go to FAIL; otherwise go to RESET and reload `C_RESET_CYCLES`.
- UP:
  - `link_ready`=1, `phyreset`=0.
  - The loss counter counts consecutive `linkup`=0 cycles and clears on any `linkup`=1.
  - On reaching `C_LOSS_DEBOUNCE`: pulse `link_lost` for one cycle, clear `retry_cnt`, go to RESET.
- FAIL: `link_fail`=1, `phyreset`=1. Stay until `enable`=0.
- Priority, highest first:
  1. `host_rst`.
  2. `enable`=0 → IDLE from any state; `retry_cnt` cleared.
  3. `plllock`=0 in states 2–6 → WAIT_PLL; `retry_cnt` unchanged, no retry counted.
  4. Normal transitions.
- Simultaneous events:
  - `CommInit`/`linkup` in the same cycle as timer expiry: success wins.
  - `linkup`=1 while still in WAIT_INIT is ignored.
- `retry_cnt` saturates at 15 and clears on entry to IDLE.

## Timing
- Reset values: state IDLE, `phyreset`=1, `StartComm`=0, `link_ready`=0, `link_fail`=0, `link_lost`=0, `retry_cnt`=0, `state_dbg`=0.
- All outputs are registered; there is no combinational path from input to output.
- Inputs are sampled at cycle N; the resulting transition and its outputs are visible at cycle N+1.
- Cycles from `enable` rising (with `plllock`=1) to the first `StartComm`: 2 + `C_RESET_CYCLES`.
- `phyreset` falls in the same cycle that `StartComm` rises.
- Timeout expiry occurs exactly `C_*_TIMEOUT` cycles after the state is entered.
- Timer width: $clog2 of the largest timeout + 1.

## Structure
- Package `sata_bringup_pkg`: state encoding constants and the `C_*` default values.
- Sub-module `sata_bringup_timer`: loadable down-counter with `load`, `value` and an `expired` flag. One instance serves the reset, init and link timers.
- The debounce counter lives inline in the top module.

## Test plan
- Happy path (`C_RESET_CYCLES`=16, `plllock`=1): raise `enable` at cycle 0; `CommInit` at cycle 100; `linkup` at cycle 200.
  - `StartComm` pulses at cycle 18.
  - `link_ready`=1 at cycle 201.
  - `retry_cnt`=0.
- Init timeout (`C_INIT_TIMEOUT`=50, `C_MAX_RETRY`=3): `CommInit` never asserts.
  - Exactly 3 `StartComm` pulses.
  - `retry_cnt`=3, `link_fail`=1, `state_dbg`=7.
  - Dropping `enable` returns the block to IDLE with `retry_cnt`=0.
- Link loss (`C_LOSS_DEBOUNCE`=8): in UP, drop `linkup` for 7 cycles then 1 cycle high.
  - No `link_lost`.
  - Then drop `linkup` for 8 cycles: `link_lost` pulses once, `link_ready`=0, `phyreset`=1 for 16 cycles, then `StartComm`.
- PLL drop: deassert `plllock` in WAIT_LINK.
  - Next cycle `state_dbg`=1 and `retry_cnt` unchanged.
  - Re-lock restarts from RESET.
- Race: `CommInit` asserted in the exact expiry cycle of WAIT_INIT.
  - Block enters WAIT_LINK; `retry_cnt` is not incremented.
- Reset mid-operation: assert `host_rst` for 1 cycle during UP.
  - All outputs return to their reset values on the next cycle.
